// File: rtl/hazard_ctrl.sv
// rtl/hazard_ctrl.sv - pipeline hazard/stall controller: load-use, IRAM structural, RAM wait, branch flush
// Stall/flush outputs are combinational; the FSM tracks RAM waits and latches a sticky timeout.
`ifndef ALU_A_OP_BUS
`define ALU_A_OP_BUS    2:0
`define ALU_A_OP_REGA   3'd1
`define ALU_A_OP_SP     3'd2
`define ALU_A_OP_T      3'd3
`endif
`ifndef ALU_B_OP_BUS
`define ALU_B_OP_BUS    1:0
`define ALU_B_OP_REGB   2'd1
`endif
`ifndef REG_OP_BUS
`define REG_OP_BUS      2:0
`define REG_OP_NOP      3'd0
`define REG_OP_REG      3'd1
`define REG_OP_SP       3'd2
`define REG_OP_T        3'd3
`define REG_OP_IH       3'd4
`endif
`ifndef WB_DATA_OP_BUS
`define WB_DATA_OP_BUS  1:0
`define WB_DATA_OP_ALU  2'd0
`define WB_DATA_OP_MEM  2'd1
`endif

module hazard_ctrl #(
  parameter int REG_ADDR_W = 4,
  parameter int WAIT_MAX   = 16,
  parameter int CNT_W      = 16
) (
  input  logic                    clk,
  input  logic                    rst,
  input  logic [REG_ADDR_W-1:0]   id_reg1_addr,
  input  logic [REG_ADDR_W-1:0]   id_reg2_addr,
  input  logic [`ALU_A_OP_BUS]    id_op1_mux_op,
  input  logic [`ALU_B_OP_BUS]    id_op2_mux_op,
  input  logic                    id_ih_read,
  input  logic [`REG_OP_BUS]      ieo_reg_op,
  input  logic [REG_ADDR_W-1:0]   ieo_wb_addr,
  input  logic [`WB_DATA_OP_BUS]  ieo_wb_data_op,
  input  logic                    branch_taken,
  input  logic                    emo_mem_req,
  input  logic                    emo_inst_space,
  input  logic                    ram_ready,
  output logic                    pc_stall,
  output logic                    ifid_stall,
  output logic                    idex_stall,
  output logic                    exmem_stall,
  output logic                    ifid_flush,
  output logic                    idex_flush,
  output logic                    exmem_flush,
  output logic                    mem_timeout,
  output logic [1:0]              hz_state,
  output logic [CNT_W-1:0]        stall_count
);

  typedef enum logic [1:0] {
    RUN      = 2'd0,
    MEM_WAIT = 2'd1,
    TIMEOUT  = 2'd2
  } state_t;

  localparam int WCNT_W = $clog2(WAIT_MAX + 1);
  localparam logic [WCNT_W-1:0] WAIT_LAST = WCNT_W'(WAIT_MAX - 1);

  state_t             state, next_state;
  logic [WCNT_W-1:0]  wait_cnt, next_wait_cnt;
  logic               next_timeout;
  logic               wait_req;
  logic               load_use;

  assign wait_req = emo_mem_req && !ram_ready && (state != TIMEOUT);

  // A load in EX whose destination the ID instruction consumes cannot be forwarded.
  always_comb begin
    load_use = 1'b0;
    if (ieo_wb_data_op == `WB_DATA_OP_MEM) begin
      case (ieo_reg_op)
        `REG_OP_REG: load_use =
            ((id_op1_mux_op == `ALU_A_OP_REGA) && (id_reg1_addr == ieo_wb_addr)) ||
            ((id_op2_mux_op == `ALU_B_OP_REGB) && (id_reg2_addr == ieo_wb_addr));
        `REG_OP_SP:  load_use = (id_op1_mux_op == `ALU_A_OP_SP);
        `REG_OP_T:   load_use = (id_op1_mux_op == `ALU_A_OP_T);
        `REG_OP_IH:  load_use = id_ih_read;
        default:     load_use = 1'b0;
      endcase
    end
  end

  always_comb begin
    pc_stall      = 1'b0;
    ifid_stall    = 1'b0;
    idex_stall    = 1'b0;
    exmem_stall   = 1'b0;
    ifid_flush    = 1'b0;
    idex_flush    = 1'b0;
    exmem_flush   = 1'b0;
    next_state    = state;
    next_wait_cnt = wait_cnt;
    next_timeout  = mem_timeout;

    if (!rst) begin
      if (wait_req) begin
        pc_stall    = 1'b1;
        ifid_stall  = 1'b1;
        idex_stall  = 1'b1;
        exmem_stall = 1'b1;
        exmem_flush = 1'b1;
        if (state == RUN) begin
          next_state    = MEM_WAIT;
          next_wait_cnt = WCNT_W'(1);
        end else if (wait_cnt == WAIT_LAST) begin
          next_state    = TIMEOUT;
          next_timeout  = 1'b1;
          next_wait_cnt = '0;
        end else begin
          next_wait_cnt = wait_cnt + 1'b1;
        end
      end else begin
        if (state == MEM_WAIT) begin
          next_state    = RUN;
          next_wait_cnt = '0;
        end
        // A branch coinciding with a structural stall stays in EX and is flushed next cycle.
        if (emo_mem_req && emo_inst_space) begin
          pc_stall    = 1'b1;
          ifid_stall  = 1'b1;
          idex_stall  = 1'b1;
          exmem_flush = 1'b1;
        end else if (branch_taken) begin
          ifid_flush = 1'b1;
          idex_flush = 1'b1;
        end else if (load_use) begin
          pc_stall   = 1'b1;
          ifid_stall = 1'b1;
          idex_flush = 1'b1;
        end
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= RUN;
      wait_cnt    <= '0;
      mem_timeout <= 1'b0;
      stall_count <= '0;
    end else begin
      state       <= next_state;
      wait_cnt    <= next_wait_cnt;
      mem_timeout <= next_timeout;
      if (pc_stall && (stall_count != {CNT_W{1'b1}}))
        stall_count <= stall_count + 1'b1;
    end
  end

  assign hz_state = state;

endmodule

// File: tb/tb_hazard_ctrl.sv
// tb/tb_hazard_ctrl.sv - self-checking bench for hazard_ctrl: vector table, corner sequences, random vs model
module tb_hazard_ctrl;
  localparam int WAIT_MAX = 4;
  localparam int CNT_W    = 5;
  localparam int CNT_MAX  = (1 << CNT_W) - 1;

  localparam logic [2:0] A_NONE = 3'd0, A_REGA = 3'd1, A_SP = 3'd2, A_T = 3'd3;
  localparam logic [1:0] B_NONE = 2'd0, B_REGB = 2'd1;
  localparam logic [2:0] R_NOP = 3'd0, R_REG = 3'd1, R_SP = 3'd2, R_T = 3'd3, R_IH = 3'd4;
  localparam logic [1:0] W_ALU = 2'd0, W_MEM = 2'd1;

  // Output vector order: {pc, ifid, idex, exmem stall, ifid, idex, exmem flush}
  localparam logic [6:0] O_NONE   = 7'b0000000;
  localparam logic [6:0] O_BUBBLE = 7'b1100010;
  localparam logic [6:0] O_BRANCH = 7'b0000110;
  localparam logic [6:0] O_STRUCT = 7'b1110001;
  localparam logic [6:0] O_WAIT   = 7'b1111001;

  logic clk = 1'b0;
  logic rst;
  logic [3:0] id_reg1_addr, id_reg2_addr, ieo_wb_addr;
  logic [2:0] id_op1_mux_op, ieo_reg_op;
  logic [1:0] id_op2_mux_op, ieo_wb_data_op;
  logic id_ih_read, branch_taken, emo_mem_req, emo_inst_space, ram_ready;
  logic pc_stall, ifid_stall, idex_stall, exmem_stall;
  logic ifid_flush, idex_flush, exmem_flush, mem_timeout;
  logic [1:0] hz_state;
  logic [CNT_W-1:0] stall_count;
  wire  [6:0] outs = {pc_stall, ifid_stall, idex_stall, exmem_stall, ifid_flush, idex_flush, exmem_flush};

  int checks = 0;
  int errors = 0;

  hazard_ctrl #(.REG_ADDR_W(4), .WAIT_MAX(WAIT_MAX), .CNT_W(CNT_W)) dut (
    .clk(clk), .rst(rst),
    .id_reg1_addr(id_reg1_addr), .id_reg2_addr(id_reg2_addr),
    .id_op1_mux_op(id_op1_mux_op), .id_op2_mux_op(id_op2_mux_op), .id_ih_read(id_ih_read),
    .ieo_reg_op(ieo_reg_op), .ieo_wb_addr(ieo_wb_addr), .ieo_wb_data_op(ieo_wb_data_op),
    .branch_taken(branch_taken), .emo_mem_req(emo_mem_req), .emo_inst_space(emo_inst_space),
    .ram_ready(ram_ready),
    .pc_stall(pc_stall), .ifid_stall(ifid_stall), .idex_stall(idex_stall), .exmem_stall(exmem_stall),
    .ifid_flush(ifid_flush), .idex_flush(idex_flush), .exmem_flush(exmem_flush),
    .mem_timeout(mem_timeout), .hz_state(hz_state), .stall_count(stall_count)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [3:0] r1, r2, wa;
    logic [2:0] op1, reg_op;
    logic [1:0] op2, wb_op;
    logic       ih, br, req, inst, rdy;
    logic [6:0] exp;
  } vec_t;

  // Reference model state: waiting, cycles waited, timed out, stall cycles seen
  bit m_wait;
  int m_wcnt;
  bit m_to;
  int m_cnt;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic idle();
    id_reg1_addr = 0; id_reg2_addr = 0; id_op1_mux_op = A_NONE; id_op2_mux_op = B_NONE;
    id_ih_read = 0; ieo_reg_op = R_NOP; ieo_wb_addr = 0; ieo_wb_data_op = W_ALU;
    branch_taken = 0; emo_mem_req = 0; emo_inst_space = 0; ram_ready = 1;
  endtask

  task automatic cyc();
    @(posedge clk); #1;
  endtask

  task automatic apply(input vec_t v);
    id_reg1_addr = v.r1; id_reg2_addr = v.r2; id_op1_mux_op = v.op1; id_op2_mux_op = v.op2;
    id_ih_read = v.ih; ieo_reg_op = v.reg_op; ieo_wb_addr = v.wa; ieo_wb_data_op = v.wb_op;
    branch_taken = v.br; emo_mem_req = v.req; emo_inst_space = v.inst; ram_ready = v.rdy;
  endtask

  task automatic do_reset();
    idle(); rst = 1; cyc(); rst = 0;
  endtask

  function automatic bit consumes_load();
    if (ieo_wb_data_op != W_MEM) return 0;
    if (ieo_reg_op == R_REG)
      return (id_op1_mux_op == A_REGA && id_reg1_addr == ieo_wb_addr) ||
             (id_op2_mux_op == B_REGB && id_reg2_addr == ieo_wb_addr);
    if (ieo_reg_op == R_SP) return id_op1_mux_op == A_SP;
    if (ieo_reg_op == R_T)  return id_op1_mux_op == A_T;
    if (ieo_reg_op == R_IH) return id_ih_read;
    return 0;
  endfunction

  function automatic logic [6:0] model_outs();
    if (rst) return O_NONE;
    if (emo_mem_req && !ram_ready && !m_to) return O_WAIT;
    if (emo_mem_req && emo_inst_space) return O_STRUCT;
    if (branch_taken) return O_BRANCH;
    if (consumes_load()) return O_BUBBLE;
    return O_NONE;
  endfunction

  task automatic model_clock(input logic [6:0] o);
    if (rst) begin
      m_wait = 0; m_wcnt = 0; m_to = 0; m_cnt = 0;
    end else begin
      if (o[6] && m_cnt < CNT_MAX) m_cnt++;
      if (emo_mem_req && !ram_ready && !m_to) begin
        if (!m_wait) begin m_wait = 1; m_wcnt = 1; end
        else if (m_wcnt == WAIT_MAX - 1) begin m_wait = 0; m_wcnt = 0; m_to = 1; end
        else m_wcnt++;
      end else begin
        m_wait = 0; m_wcnt = 0;
      end
    end
  endtask

  vec_t vecs[16];

  initial begin
    vecs[0]  = '{r1:0, r2:1, wa:1, op1:A_NONE, reg_op:R_REG, op2:B_REGB, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_BUBBLE};
    vecs[1]  = '{r1:0, r2:2, wa:1, op1:A_NONE, reg_op:R_REG, op2:B_REGB, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};
    vecs[2]  = '{r1:0, r2:1, wa:1, op1:A_NONE, reg_op:R_REG, op2:B_REGB, wb_op:W_ALU, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};
    vecs[3]  = '{r1:5, r2:0, wa:5, op1:A_REGA, reg_op:R_REG, op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_BUBBLE};
    vecs[4]  = '{r1:5, r2:0, wa:5, op1:A_SP,   reg_op:R_REG, op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};
    vecs[5]  = '{r1:0, r2:0, wa:3, op1:A_SP,   reg_op:R_SP,  op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_BUBBLE};
    vecs[6]  = '{r1:0, r2:0, wa:3, op1:A_T,    reg_op:R_SP,  op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};
    vecs[7]  = '{r1:0, r2:0, wa:0, op1:A_T,    reg_op:R_T,   op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_BUBBLE};
    vecs[8]  = '{r1:0, r2:0, wa:0, op1:A_NONE, reg_op:R_IH,  op2:B_NONE, wb_op:W_MEM, ih:1, br:0, req:0, inst:0, rdy:1, exp:O_BUBBLE};
    vecs[9]  = '{r1:0, r2:0, wa:0, op1:A_NONE, reg_op:R_IH,  op2:B_NONE, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};
    vecs[10] = '{r1:0, r2:0, wa:0, op1:A_NONE, reg_op:R_NOP, op2:B_NONE, wb_op:W_ALU, ih:0, br:1, req:0, inst:0, rdy:1, exp:O_BRANCH};
    vecs[11] = '{r1:0, r2:1, wa:1, op1:A_NONE, reg_op:R_REG, op2:B_REGB, wb_op:W_MEM, ih:0, br:1, req:0, inst:0, rdy:1, exp:O_BRANCH};
    vecs[12] = '{r1:0, r2:0, wa:0, op1:A_NONE, reg_op:R_NOP, op2:B_NONE, wb_op:W_ALU, ih:0, br:0, req:1, inst:1, rdy:1, exp:O_STRUCT};
    vecs[13] = '{r1:0, r2:0, wa:0, op1:A_NONE, reg_op:R_NOP, op2:B_NONE, wb_op:W_ALU, ih:0, br:0, req:1, inst:0, rdy:1, exp:O_NONE};
    vecs[14] = '{r1:0, r2:1, wa:1, op1:A_NONE, reg_op:R_REG, op2:B_REGB, wb_op:W_MEM, ih:0, br:0, req:1, inst:1, rdy:1, exp:O_STRUCT};
    vecs[15] = '{r1:0, r2:1, wa:1, op1:A_NONE, reg_op:R_NOP, op2:B_REGB, wb_op:W_MEM, ih:0, br:0, req:0, inst:0, rdy:1, exp:O_NONE};

    // Reset gating: even a RAM wait request must not stall while rst is high
    idle(); rst = 1; emo_mem_req = 1; ram_ready = 0;
    cyc(); cyc();
    @(negedge clk);
    chk("reset_outs", outs, O_NONE);
    chk("reset_state", hz_state, 0);
    chk("reset_timeout", mem_timeout, 0);
    chk("reset_count", stall_count, 0);
    cyc(); rst = 0; idle(); cyc();

    foreach (vecs[i]) begin
      apply(vecs[i]);
      @(negedge clk);
      chk($sformatf("vec%0d", i), outs, vecs[i].exp);
      cyc();
    end

    // Load-use: exactly one bubble, then the NOP in EX releases the pipe
    do_reset();
    apply(vecs[0]);
    @(negedge clk); chk("lu_bubble", outs, O_BUBBLE); chk("lu_count0", stall_count, 0);
    cyc(); idle(); id_op2_mux_op = B_REGB; id_reg2_addr = 1;
    @(negedge clk); chk("lu_release", outs, O_NONE); chk("lu_count1", stall_count, 1);

    // RAM wait for three cycles then ready
    do_reset();
    emo_mem_req = 1; ram_ready = 0;
    for (int k = 1; k <= 3; k++) begin
      @(negedge clk);
      chk($sformatf("wait_outs%0d", k), outs, O_WAIT);
      chk($sformatf("wait_state%0d", k), hz_state, (k == 1) ? 0 : 1);
      cyc();
    end
    ram_ready = 1;
    @(negedge clk); chk("wait_ready_outs", outs, O_NONE); chk("wait_ready_state", hz_state, 1);
    cyc(); idle();
    @(negedge clk); chk("wait_end_state", hz_state, 0); chk("wait_count", stall_count, 3);

    // Structural conflict defers a simultaneous branch by one cycle
    do_reset();
    emo_mem_req = 1; emo_inst_space = 1; ram_ready = 1; branch_taken = 1;
    @(negedge clk); chk("struct_br_c1", outs, O_STRUCT);
    cyc(); emo_mem_req = 0; emo_inst_space = 0;
    @(negedge clk); chk("struct_br_c2", outs, O_BRANCH);
    cyc(); idle();

    // Timeout after WAIT_MAX cycles, sticky until reset
    do_reset();
    emo_mem_req = 1; ram_ready = 0;
    for (int k = 1; k <= WAIT_MAX; k++) begin
      @(negedge clk); chk($sformatf("to_stall%0d", k), outs, O_WAIT); cyc();
    end
    @(negedge clk);
    chk("to_flag", mem_timeout, 1); chk("to_state", hz_state, 2); chk("to_outs", outs, O_NONE);
    emo_inst_space = 1;
    @(negedge clk); chk("to_struct_live", outs, O_STRUCT);
    cyc(); cyc(); emo_inst_space = 0;
    @(negedge clk); chk("to_sticky", mem_timeout, 1);
    rst = 1; cyc();
    @(negedge clk);
    chk("to_rst_flag", mem_timeout, 0); chk("to_rst_state", hz_state, 0); chk("to_rst_count", stall_count, 0);
    rst = 0; idle(); cyc();

    // Reset in the middle of a wait returns to RUN regardless of ram_ready
    emo_mem_req = 1; ram_ready = 0; cyc(); cyc();
    rst = 1;
    @(negedge clk); chk("midwait_rst_outs", outs, O_NONE);
    cyc(); rst = 0;
    @(negedge clk); chk("midwait_rst_state", hz_state, 0); chk("midwait_rst_count", stall_count, 0);
    idle(); cyc();

    // Counter saturation
    emo_mem_req = 1; emo_inst_space = 1;
    repeat (CNT_MAX + 5) cyc();
    @(negedge clk); chk("sat_count", stall_count, CNT_MAX);
    idle(); do_reset();

    // Randomised run against the reference model
    m_wait = 0; m_wcnt = 0; m_to = 0; m_cnt = 0;
    for (int i = 0; i < 1500; i++) begin
      logic [6:0] eo;
      bit stuck;
      stuck = (i % 97) < 8;
      rst            = ($urandom_range(0, 59) == 0);
      id_reg1_addr   = 4'($urandom_range(0, 3));
      id_reg2_addr   = 4'($urandom_range(0, 3));
      id_op1_mux_op  = 3'($urandom_range(0, 3));
      id_op2_mux_op  = 2'($urandom_range(0, 2));
      id_ih_read     = 1'($urandom_range(0, 1));
      ieo_reg_op     = 3'($urandom_range(0, 4));
      ieo_wb_addr    = 4'($urandom_range(0, 3));
      ieo_wb_data_op = 2'($urandom_range(0, 2));
      branch_taken   = ($urandom_range(0, 3) == 0);
      emo_mem_req    = stuck || ($urandom_range(0, 2) == 0);
      emo_inst_space = ($urandom_range(0, 2) == 0);
      ram_ready      = !stuck && ($urandom_range(0, 3) != 0);
      @(negedge clk);
      eo = model_outs();
      chk("rnd_outs", outs, eo);
      chk("rnd_state", hz_state, m_to ? 2 : (m_wait ? 1 : 0));
      chk("rnd_timeout", mem_timeout, m_to);
      chk("rnd_count", stall_count, m_cnt);
      @(posedge clk);
      model_clock(eo);
      #1;
    end

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/hazard_ctrl.md
Name: hazard_ctrl

Overview:
- Pipeline hazard and stall controller for the 5-stage core.
- Covers every hazard that forwarding cannot resolve:
  - load-use on GPR, SP, T or IH;
  - structural conflict between a MEM-stage data access to instruction RAM and IF fetch;
  - multi-cycle RAM waits;
  - taken-branch flushes.
- Drives stall and flush controls into PC, IF/ID, ID/EX and EX/MEM registers; keeps a stall-cycle counter and a sticky RAM timeout error.

Parameters:
REG_ADDR_W, 4, width of register address fields (matches `REG_ADDR_BUS)
WAIT_MAX, 16, max consecutive MEM_WAIT cycles before timeout
CNT_W, 16, stall_count width

Ports:
clk  in  1  system clock
rst  in  1  synchronous active-high reset
id_reg1_addr  in  REG_ADDR_W  ID-stage source 1 address
id_reg2_addr  in  REG_ADDR_W  ID-stage source 2 address
id_op1_mux_op  in  `ALU_A_OP_BUS  ID-stage operand A select
id_op2_mux_op  in  `ALU_B_OP_BUS  ID-stage operand B select
id_ih_read  in  1  ID instruction reads IH
ieo_reg_op  in  `REG_OP_BUS  EX-stage destination class
ieo_wb_addr  in  REG_ADDR_W  EX-stage destination address
ieo_wb_data_op  in  `WB_DATA_OP_BUS  EX-stage writeback source
branch_taken  in  1  EX-stage branch/jump resolved taken
emo_mem_req  in  1  MEM stage performs RAM read/write
emo_inst_space  in  1  MEM access targets instruction RAM
ram_ready  in  1  RAM completes access this cycle
pc_stall  out  1  hold PC
ifid_stall  out  1  hold IF/ID
idex_stall  out  1  hold ID/EX
exmem_stall  out  1  hold EX/MEM
ifid_flush  out  1  load NOP into IF/ID
idex_flush  out  1  load NOP into ID/EX
exmem_flush  out  1  load NOP into MEM/WB
mem_timeout  out  1  sticky RAM timeout error
hz_state  out  2  FSM state: 0 RUN, 1 MEM_WAIT, 2 TIMEOUT
stall_count  out  CNT_W  saturating count of cycles with pc_stall=1

Behaviour:
- Reset, synchronous on rst=1:
  - state RUN; wait_cnt 0; mem_timeout 0; stall_count 0.
  - All stall/flush outputs 0 in the reset cycle.
- Stall/flush outputs are combinational from current state and inputs, same cycle. State, wait_cnt, mem_timeout and stall_count are registered.
- Priority, first match wins:
  1. RAM wait: emo_mem_req=1, ram_ready=0, state≠TIMEOUT.
     - pc, ifid, idex, exmem stall=1; exmem_flush=1.
     - Next state MEM_WAIT.
  2. Structural: emo_mem_req=1, emo_inst_space=1, wait not active.
     - pc, ifid, idex stall=1; exmem_flush=1.
     - A simultaneous branch_taken is not flushed this cycle; it is honoured the next cycle.
  3. Branch: branch_taken=1.
     - ifid_flush=1, idex_flush=1, no stalls.
  4. Load-use: ieo_wb_data_op=`WB_DATA_OP_MEM and any of:
     - ieo_reg_op=`REG_OP_REG, id_op1_mux_op=`ALU_A_OP_REGA, id_reg1_addr=ieo_wb_addr;
     - ieo_reg_op=`REG_OP_REG, id_op2_mux_op=`ALU_B_OP_REGB, id_reg2_addr=ieo_wb_addr;
     - ieo_reg_op=`REG_OP_SP, id_op1_mux_op=`ALU_A_OP_SP;
     - ieo_reg_op=`REG_OP_T, id_op1_mux_op=`ALU_A_OP_T;
     - ieo_reg_op=`REG_OP_IH, id_ih_read=1.
     - Response: pc_stall=1, ifid_stall=1, idex_flush=1. Exactly one bubble; the bubble carries a NOP reg_op, so there is no re-trigger.
  5. Otherwise all outputs 0.
- FSM:
  - RUN→MEM_WAIT on rule 1; wait_cnt←1.
  - In MEM_WAIT:
    - ram_ready=1 or emo_mem_req=0: →RUN, wait_cnt←0. Rules 2–5 are evaluated that cycle.
    - Otherwise, if wait_cnt=WAIT_MAX-1: →TIMEOUT, mem_timeout←1. Stalls are still asserted that cycle.
    - Otherwise wait_cnt+1.
  - TIMEOUT: rule 1 is masked (ram treated ready); rules 2–5 are active. Exit only by rst.
- stall_count:
  - +1 each cycle pc_stall=1.
  - Saturates at all-ones with no wrap.
- rst mid-MEM_WAIT: next cycle RUN and outputs deasserted regardless of ram_ready.

Test Plan:
- LW R1 in EX (wb_op MEM, reg_op REG, addr 1); ID uses R1 as REGB.
  → exactly one cycle pc_stall=ifid_stall=idex_flush=1; stall_count 0→1.
- Same, but ID uses R2 or EX wb_op=ALU.
  → no stall.
- SP load-use and IH load-use (id_ih_read=1).
  → each gives one bubble.
- emo_mem_req=1, ram_ready=0 for 3 cycles, then 1.
  → hz_state 1 for 3 cycles; all stalls and exmem_flush=1 for 3 cycles; release on ready cycle; stall_count=3.
- emo_mem_req=1, emo_inst_space=1, ram_ready=1, branch_taken=1.
  → cycle 1: pc/ifid/idex stall, exmem_flush, no ifid_flush.
  → cycle 2 (req=0): ifid_flush=idex_flush=1.
- ram_ready held 0 with WAIT_MAX=4.
  → stalls for 4 cycles, mem_timeout=1, hz_state=2, stalls drop.
  → rst → mem_timeout=0, hz_state=0, stall_count=0.
